// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator (hsync/vsync, active, x/y, strobes)
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic       clk_25,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       HS_ON   = (H_POL != 0);
  localparam logic       VS_ON   = (V_POL != 0);

  logic [9:0] nx;
  logic [9:0] ny;
  logic       n_frame_start;

  // Outputs are registered from the next-state counters so every output
  // describes the same (x,y) in a given cycle.
  always_comb begin
    nx = x + 10'd1;
    ny = y;
    if (x == H_LAST) begin
      nx = '0;
      ny = (y == V_LAST) ? '0 : y + 10'd1;
    end
    n_frame_start = (nx == '0) && (ny == '0);
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      x           <= H_LAST;
      y           <= V_LAST;
      active      <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= nx;
      y           <= ny;
      active      <= (nx < H_ACT) && (ny < V_ACT);
      hsync       <= ((nx >= HS_BEG) && (nx < HS_END)) ? HS_ON : ~HS_ON;
      vsync       <= ((ny >= VS_BEG) && (ny < VS_END)) ? VS_ON : ~VS_ON;
      line_start  <= (nx == '0);
      frame_start <= n_frame_start;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fcnt_q;
  logic       first_seen;

  // The first frame start after reset is not a completed frame, so skip it.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      fcnt_q     <= '0;
      first_seen <= 1'b0;
    end else if (n_frame_start) begin
      first_seen <= 1'b1;
      if (first_seen) fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - scoreboard bench for vga_timing (640x480 and 8x4 rasters)
module tb_vga_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b = 1'b1;
  logic rst_s = 1'b1;

  logic       hs_b, vs_b, act_b, ls_b, fs_b;
  logic [9:0] x_b, y_b;
  logic [7:0] fc_b;
  logic       hs_s, vs_s, act_s, ls_s, fs_s;
  logic [9:0] x_s, y_s;
  logic [7:0] fc_s;

  vga_timing dut_b (
    .clk_25(clk), .rst(rst_b), .hsync(hs_b), .vsync(vs_b), .active(act_b),
    .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  vga_timing #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1)
  ) dut_s (
    .clk_25(clk), .rst(rst_s), .hsync(hs_s), .vsync(vs_s), .active(act_s),
    .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int t_b    = -1;
  int t_s    = -1;
  logic [32:0] q_b[$];
  logic [32:0] q_s[$];
  logic [32:0] eb, es;

  wire [32:0] obs_b = {hs_b, vs_b, act_b, x_b, y_b, ls_b, fs_b, fc_b};
  wire [32:0] obs_s = {hs_s, vs_s, act_s, x_s, y_s, ls_s, fs_s, fc_s};

  // Reference raster from cycles elapsed since reset release (t < 0: in reset).
  function automatic logic [32:0] model(input int t, input int ha, input int hf,
      input int hw, input int hb, input int va, input int vf, input int vw,
      input int vb, input bit hp, input bit vp);
    int ht, vt, xm, ym, fc;
    logic h, v, a, l, f;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    if (t < 0) return {~hp, ~vp, 1'b0, 10'(ht - 1), 10'(vt - 1), 1'b0, 1'b0, 8'd0};
    xm = t % ht;
    ym = (t / ht) % vt;
`ifdef VGA_TIMING_FRAME_CNT_EN
    fc = (t / (ht * vt)) % 256;
`else
    fc = 0;
`endif
    a = (xm < ha) && (ym < va);
    h = (xm >= ha + hf && xm < ha + hf + hw) ? hp : ~hp;
    v = (ym >= va + vf && ym < va + vf + vw) ? vp : ~vp;
    l = (xm == 0);
    f = (xm == 0) && (ym == 0);
    return {h, v, a, 10'(xm), 10'(ym), l, f, 8'(fc)};
  endfunction

  task automatic tick(input logic rb, input logic rs);
    rst_b = rb;
    rst_s = rs;
    t_b = rb ? -1 : t_b + 1;
    t_s = rs ? -1 : t_s + 1;
    q_b.push_back(model(t_b, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
    q_s.push_back(model(t_s, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      tick(i < 3, i < 3);
      eb = q_b.pop_front();
      es = q_s.pop_front();
      n_chk += 2;
      if (obs_b !== eb) begin
        n_fail++;
        $display("FAIL reset_big cyc=%0d got=%h exp=%h", i, obs_b, eb);
      end
      if (obs_s !== es) begin
        n_fail++;
        $display("FAIL reset_small cyc=%0d got=%h exp=%h", i, obs_s, es);
      end
    end
    n_chk++;
    if (!(x_b == 10'd0 && y_b == 10'd0 && act_b && fs_b && ls_b)) begin
      n_fail++;
      $display("FAIL first_pixel got x=%0d y=%0d act=%b fs=%b ls=%b exp 0 0 1 1 1",
               x_b, y_b, act_b, fs_b, ls_b);
    end
  endtask

  task automatic test_line;
    int n_hs, n_act, n_ls;
    n_hs = 0; n_act = 0; n_ls = 0;
    for (int i = 0; i < 800; i++) begin
      tick(1'b0, 1'b0);
      eb = q_b.pop_front();
      es = q_s.pop_front();
      n_chk += 2;
      if (obs_b !== eb) begin
        n_fail++;
        $display("FAIL line_big t=%0d got=%h exp=%h", t_b, obs_b, eb);
      end
      if (obs_s !== es) begin
        n_fail++;
        $display("FAIL line_small t=%0d got=%h exp=%h", t_s, obs_s, es);
      end
      n_hs  += (hs_b == 1'b0) ? 1 : 0;
      n_act += act_b ? 1 : 0;
      n_ls  += ls_b ? 1 : 0;
    end
    n_chk += 3;
    if (n_hs != 96) begin
      n_fail++;
      $display("FAIL hsync_width got=%0d exp=96", n_hs);
    end
    if (n_act != 640) begin
      n_fail++;
      $display("FAIL active_count got=%0d exp=640", n_act);
    end
    if (n_ls != 1) begin
      n_fail++;
      $display("FAIL line_period got=%0d pulses exp=1", n_ls);
    end
  endtask

  task automatic test_frame;
    int n_fs, n_vs, n_hs, first_fs, last_fs;
    logic prev_vs;
    n_fs = 0; n_vs = 0; n_hs = 0; first_fs = -1; last_fs = -1;
    prev_vs = vs_s;
    for (int i = 0; i < 168; i++) begin
      tick(1'b0, 1'b0);
      eb = q_b.pop_front();
      es = q_s.pop_front();
      n_chk += 2;
      if (obs_b !== eb) begin
        n_fail++;
        $display("FAIL frame_big t=%0d got=%h exp=%h", t_b, obs_b, eb);
      end
      if (obs_s !== es) begin
        n_fail++;
        $display("FAIL frame_small t=%0d got=%h exp=%h", t_s, obs_s, es);
      end
      if (vs_s !== prev_vs && x_s !== 10'd0) begin
        n_chk++;
        n_fail++;
        $display("FAIL vsync_edge x=%0d exp=0", x_s);
      end
      prev_vs = vs_s;
      if (fs_s) begin
        n_fs++;
        if (first_fs < 0) first_fs = i;
        last_fs = i;
      end
      n_vs += vs_s ? 1 : 0;
      n_hs += hs_s ? 1 : 0;
    end
    n_chk += 4;
    if (n_fs != 2) begin
      n_fail++;
      $display("FAIL frame_pulses got=%0d exp=2", n_fs);
    end
    if (last_fs - first_fs != 84) begin
      n_fail++;
      $display("FAIL frame_period got=%0d exp=84", last_fs - first_fs);
    end
    if (n_vs != 24) begin
      n_fail++;
      $display("FAIL vsync_width got=%0d exp=24", n_vs);
    end
    if (n_hs != 28) begin
      n_fail++;
      $display("FAIL hsync_small_width got=%0d exp=28", n_hs);
    end
  endtask

  task automatic test_mid_reset;
    int guard;
    guard = 0;
    while (!(x_b == 10'd300 && y_b == 10'd1) && guard < 2000) begin
      tick(1'b0, 1'b0);
      void'(q_b.pop_front());
      void'(q_s.pop_front());
      guard++;
    end
    n_chk++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL mid_reset_reach got x=%0d y=%0d exp x=300 y=1", x_b, y_b);
    end
    for (int i = 0; i < 2; i++) begin
      tick(i == 0, i == 0);
      eb = q_b.pop_front();
      es = q_s.pop_front();
      n_chk += 2;
      if (obs_b !== eb) begin
        n_fail++;
        $display("FAIL mid_reset_big cyc=%0d got=%h exp=%h", i, obs_b, eb);
      end
      if (obs_s !== es) begin
        n_fail++;
        $display("FAIL mid_reset_small cyc=%0d got=%h exp=%h", i, obs_s, es);
      end
    end
    n_chk++;
    if (!(x_b == 10'd0 && y_b == 10'd0 && fs_b)) begin
      n_fail++;
      $display("FAIL mid_reset_restart got x=%0d y=%0d fs=%b exp 0 0 1", x_b, y_b, fs_b);
    end
  endtask

  task automatic test_frame_cnt;
    logic [7:0] exp_fc;
    for (int i = 0; i < 257 * 84; i++) begin
      tick(1'b0, 1'b0);
      eb = q_b.pop_front();
      es = q_s.pop_front();
      n_chk += 2;
      if (obs_b !== eb) begin
        n_fail++;
        $display("FAIL cnt_big t=%0d got=%h exp=%h", t_b, obs_b, eb);
      end
      if (obs_s !== es) begin
        n_fail++;
        $display("FAIL cnt_small t=%0d got=%h exp=%h", t_s, obs_s, es);
      end
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    exp_fc = 8'd1;
`else
    exp_fc = 8'd0;
`endif
    n_chk++;
    if (fc_s !== exp_fc) begin
      n_fail++;
      $display("FAIL frame_cnt_wrap got=%0d exp=%0d", fc_s, exp_fc);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_frame_cnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
